// File: rtl/timer_reg_core.sv
// Register block of a 64-bit free-running timer with optional power-of-two prescaler,
// 64-bit compare and a level interrupt; zero-latency register reads.
module timer_reg_core #(
  parameter int ADDR_W = 12
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] tim_paddr,
  input  logic [31:0]       tim_pwdata,
  input  logic [3:0]        tim_pstrb,
  output logic [31:0]       rdata,
  output logic              tim_int
);

  // Strobe semantics: wr_en / rd_en are single-cycle qualifiers from the APB slave
  // stage; a write commits at the rising edge where wr_en=1, read data is valid
  // combinationally during the cycle rd_en=1 and is 0 otherwise. No back-pressure.

  localparam logic [ADDR_W-1:0] A_TCR   = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] A_TDR0  = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] A_TDR1  = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] A_TCMP0 = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] A_TCMP1 = ADDR_W'(32'h10);
  localparam logic [ADDR_W-1:0] A_TIER  = ADDR_W'(32'h14);
  localparam logic [ADDR_W-1:0] A_TISR  = ADDR_W'(32'h18);

  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic [63:0] cnt;
  logic [63:0] cmp;
  logic        int_en;
  logic        int_st;
  logic [7:0]  presc;

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  logic wr_tcr, wr_tdr0, wr_tdr1, wr_tcmp0, wr_tcmp1, wr_tier, wr_tisr;
  assign wr_tcr   = wr_en && (tim_paddr == A_TCR);
  assign wr_tdr0  = wr_en && (tim_paddr == A_TDR0);
  assign wr_tdr1  = wr_en && (tim_paddr == A_TDR1);
  assign wr_tcmp0 = wr_en && (tim_paddr == A_TCMP0);
  assign wr_tcmp1 = wr_en && (tim_paddr == A_TCMP1);
  assign wr_tier  = wr_en && (tim_paddr == A_TIER);
  assign wr_tisr  = wr_en && (tim_paddr == A_TISR);

  // Candidate TCR contents after the write; rejected as a whole when div_val > 8.
  logic [1:0] tcr_lo_new;
  logic [3:0] tcr_div_new;
  logic       tcr_ok;
  logic       tcr_div_chg;
  assign tcr_lo_new  = tim_pstrb[0] ? tim_pwdata[1:0]  : {div_en, timer_en};
  assign tcr_div_new = tim_pstrb[1] ? tim_pwdata[11:8] : div_val;
  assign tcr_ok      = (tcr_div_new <= 4'd8);
  assign tcr_div_chg = wr_tcr && tcr_ok &&
                       ((tcr_div_new != div_val) || (tcr_lo_new[1] != div_en));

  logic [7:0] presc_last;
  logic       tick;
  assign presc_last = 8'((9'd1 << div_val) - 9'd1);
  assign tick       = timer_en && (!div_en || (presc == presc_last));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer_en <= 1'b0;
      div_en   <= 1'b0;
      div_val  <= 4'd0;
    end else if (wr_tcr && tcr_ok) begin
      timer_en <= tcr_lo_new[0];
      div_en   <= tcr_lo_new[1];
      div_val  <= tcr_div_new;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc <= 8'd0;
    end else if (!timer_en || !div_en || tcr_div_chg || tick) begin
      presc <= 8'd0;
    end else begin
      presc <= presc + 8'd1;
    end
  end

  // A counter write freezes the other half for that cycle instead of ticking.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= 64'd0;
    end else if (wr_tdr0) begin
      cnt <= {cnt[63:32], lane_merge(cnt[31:0], tim_pwdata, tim_pstrb)};
    end else if (wr_tdr1) begin
      cnt <= {lane_merge(cnt[63:32], tim_pwdata, tim_pstrb), cnt[31:0]};
    end else if (tick) begin
      cnt <= cnt + 64'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cmp    <= '1;
      int_en <= 1'b0;
    end else begin
      if (wr_tcmp0) cmp[31:0]  <= lane_merge(cmp[31:0], tim_pwdata, tim_pstrb);
      if (wr_tcmp1) cmp[63:32] <= lane_merge(cmp[63:32], tim_pwdata, tim_pstrb);
      if (wr_tier && tim_pstrb[0]) int_en <= tim_pwdata[0];
    end
  end

  // Set has priority over write-1-to-clear.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      int_st <= 1'b0;
    end else if (cnt == cmp) begin
      int_st <= 1'b1;
    end else if (wr_tisr && tim_pstrb[0] && tim_pwdata[0]) begin
      int_st <= 1'b0;
    end
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = 32'd0;
    case (tim_paddr)
      A_TCR:   rd_mux = {20'd0, div_val, 6'd0, div_en, timer_en};
      A_TDR0:  rd_mux = cnt[31:0];
      A_TDR1:  rd_mux = cnt[63:32];
      A_TCMP0: rd_mux = cmp[31:0];
      A_TCMP1: rd_mux = cmp[63:32];
      A_TIER:  rd_mux = {31'd0, int_en};
      A_TISR:  rd_mux = {31'd0, int_st};
      default: rd_mux = 32'd0;
    endcase
  end

  assign rdata   = rd_en ? rd_mux : 32'd0;
  assign tim_int = int_st & int_en;

endmodule

// File: tb/tb_timer_reg_core.sv
// Directed bench for timer_reg_core: cycle-level behavioural model checked every
// falling edge, plus hand-computed register readbacks.
module tb_timer_reg_core;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] rdata;
  logic        tim_int;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  timer_reg_core #(.ADDR_W(12)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .tim_paddr  (tim_paddr),
    .tim_pwdata (tim_pwdata),
    .tim_pstrb  (tim_pstrb),
    .rdata      (rdata),
    .tim_int    (tim_int)
  );

  // ---------------- clock / watchdog ----------------
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural model ----------------
  // Ticks: while enabled, the e-th enabled cycle since the divider was last
  // (re)configured produces a tick when (e+1) is a multiple of 2^div_val.
  logic [31:0]     m_tcr;
  logic [63:0]     m_cnt, m_cmp;
  logic            m_int_en, m_int_st;
  longint unsigned m_epoch;

  logic [31:0]     mn_tcr, m_tcr_w;
  logic [63:0]     mn_cnt, mn_cmp;
  logic            mn_int_en, mn_int_st, m_tick, m_clr;
  longint unsigned mn_epoch;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    mn_tcr    = m_tcr;
    mn_cnt    = m_cnt;
    mn_cmp    = m_cmp;
    mn_int_en = m_int_en;
    m_clr     = 1'b0;
    m_tcr_w   = merge(m_tcr, tim_pwdata, tim_pstrb) & 32'h0000_0F03;
    m_tick    = m_tcr[0] && (!m_tcr[1] ||
                ((m_epoch + 1) % (64'd1 << m_tcr[11:8])) == 0);
    mn_epoch  = m_tcr[0] ? m_epoch + 1 : 0;
    if (m_tick) mn_cnt = m_cnt + 64'd1;
    if (wr_en) begin
      case (tim_paddr)
        12'h000: if (m_tcr_w[11:8] <= 4'd8) begin
                   if (m_tcr_w[11:8] != m_tcr[11:8] || m_tcr_w[1] != m_tcr[1]) mn_epoch = 0;
                   mn_tcr = m_tcr_w;
                 end
        12'h004: mn_cnt = {m_cnt[63:32], merge(m_cnt[31:0], tim_pwdata, tim_pstrb)};
        12'h008: mn_cnt = {merge(m_cnt[63:32], tim_pwdata, tim_pstrb), m_cnt[31:0]};
        12'h00C: mn_cmp[31:0]  = merge(m_cmp[31:0], tim_pwdata, tim_pstrb);
        12'h010: mn_cmp[63:32] = merge(m_cmp[63:32], tim_pwdata, tim_pstrb);
        12'h014: if (tim_pstrb[0]) mn_int_en = tim_pwdata[0];
        12'h018: m_clr = tim_pstrb[0] && tim_pwdata[0];
        default: ;
      endcase
    end
    mn_int_st = (m_cnt == m_cmp) ? 1'b1 : (m_clr ? 1'b0 : m_int_st);
  end

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_tcr    <= 32'd0;
      m_cnt    <= 64'd0;
      m_cmp    <= '1;
      m_int_en <= 1'b0;
      m_int_st <= 1'b0;
      m_epoch  <= 0;
    end else begin
      m_tcr    <= mn_tcr;
      m_cnt    <= mn_cnt;
      m_cmp    <= mn_cmp;
      m_int_en <= mn_int_en;
      m_int_st <= mn_int_st;
      m_epoch  <= mn_epoch;
    end
  end

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h000: return m_tcr;
      12'h004: return m_cnt[31:0];
      12'h008: return m_cnt[63:32];
      12'h00C: return m_cmp[31:0];
      12'h010: return m_cmp[63:32];
      12'h014: return {31'd0, m_int_en};
      12'h018: return {31'd0, m_int_st};
      default: return 32'd0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge sys_clk) begin
    chk("model_tim_int", {31'd0, tim_int}, {31'd0, m_int_st & m_int_en});
    chk("model_rdata", rdata, rd_en ? model_read(tim_paddr) : 32'd0);
  end

  // ---------------- driver tasks (start and end at posedge+1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    wr_en = 1'b1; tim_paddr = a; tim_pwdata = d; tim_pstrb = s;
    @(posedge sys_clk);
    #1;
    wr_en = 1'b0; tim_pstrb = 4'h0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    rd_en = 1'b1; tim_paddr = a;
    exp_q.push_back(exp);
    @(negedge sys_clk);
    chk(name, rdata, exp_q.pop_front());
    @(posedge sys_clk);
    #1;
    rd_en = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    sys_rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tim_paddr = '0; tim_pwdata = '0; tim_pstrb = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_tim_int", {31'd0, tim_int}, 32'd0);
    chk("rst_rdata_idle", rdata, 32'd0);
    sys_rst_n = 1'b1;
    idle(1);

    // reset readback
    rd("rst_tcr",   12'h000, 32'h0000_0000);
    rd("rst_tdr0",  12'h004, 32'h0000_0000);
    rd("rst_tdr1",  12'h008, 32'h0000_0000);
    rd("rst_tcmp0", 12'h00C, 32'hFFFF_FFFF);
    rd("rst_tcmp1", 12'h010, 32'hFFFF_FFFF);
    rd("rst_tier",  12'h014, 32'h0000_0000);
    rd("rst_tisr",  12'h018, 32'h0000_0000);
    rd("rst_unmap", 12'h01C, 32'h0000_0000);

    // prescaled counting: div_val=2 -> one tick per 4 cycles
    wr(12'h000, 32'h0000_0203);
    idle(40);
    rd("presc_tdr0", 12'h004, 32'd10);
    wr(12'h000, 32'h0000_0903);
    rd("tcr_reject", 12'h000, 32'h0000_0203);
    wr(12'h000, 32'h0000_0000);

    // carry and wrap, one tick each
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h008, 32'h0000_0000);
    wr(12'h000, 32'h0000_0001);
    wr(12'h000, 32'h0000_0000);
    rd("carry_tdr1", 12'h008, 32'h0000_0001);
    rd("carry_tdr0", 12'h004, 32'h0000_0000);
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h008, 32'hFFFF_FFFF);
    wr(12'h000, 32'h0000_0001);
    wr(12'h000, 32'h0000_0000);
    rd("wrap_tdr0", 12'h004, 32'h0000_0000);
    rd("wrap_tdr1", 12'h008, 32'h0000_0000);

    // compare interrupt
    wr(12'h00C, 32'h0000_0010);
    wr(12'h010, 32'h0000_0000);
    wr(12'h018, 32'h0000_0001);
    wr(12'h014, 32'h0000_0001);
    chk("cmp_int_idle", {31'd0, tim_int}, 32'd0);
    wr(12'h000, 32'h0000_0001);
    idle(16);
    chk("cmp_int_at_match", {31'd0, tim_int}, 32'd0);
    idle(1);
    chk("cmp_int_rise", {31'd0, tim_int}, 32'd1);
    wr(12'h018, 32'h0000_0001);
    chk("cmp_int_w1c", {31'd0, tim_int}, 32'd0);
    wr(12'h000, 32'h0000_0000);
    wr(12'h004, 32'h0000_0010);
    idle(1);
    chk("cmp_int_reset", {31'd0, tim_int}, 32'd1);
    wr(12'h014, 32'h0000_0000);
    chk("tier_mask", {31'd0, tim_int}, 32'd0);
    rd("tisr_kept", 12'h018, 32'd1);

    // W1C coinciding with a match, write-0, then a real clear
    wr(12'h018, 32'h0000_0001);
    rd("w1c_vs_set", 12'h018, 32'd1);
    wr(12'h004, 32'h0000_0020);
    wr(12'h018, 32'h0000_0000);
    rd("tisr_w0", 12'h018, 32'd1);
    wr(12'h018, 32'h0000_0001);
    rd("tisr_clr", 12'h018, 32'd0);

    // counter write beats a tick; upper half not carried that cycle
    wr(12'h008, 32'h0000_0005);
    wr(12'h004, 32'hFFFF_FFFF);
    wr(12'h000, 32'h0000_0001);
    wr(12'h004, 32'h0000_00AA, 4'b0001);
    rd("wr_vs_tick_tdr0", 12'h004, 32'hFFFF_FFAA);
    rd("wr_vs_tick_tdr1", 12'h008, 32'h0000_0005);
    wr(12'h000, 32'h0000_0000);

    // byte strobes
    wr(12'h00C, 32'hFFFF_FFFF);
    wr(12'h00C, 32'hAABB_CCDD, 4'b0101);
    rd("strb_tcmp0", 12'h00C, 32'hFFBB_FFDD);

    // reserved bits and div_val boundary
    wr(12'h000, 32'hFFFF_F4FC);
    rd("tcr_reserved", 12'h000, 32'h0000_0400);
    wr(12'h000, 32'h0000_0800);
    rd("tcr_div8", 12'h000, 32'h0000_0800);
    wr(12'h000, 32'h0000_0900, 4'b0010);
    rd("tcr_div9", 12'h000, 32'h0000_0800);
    wr(12'h014, 32'hFFFF_FFFE);
    rd("tier_reserved", 12'h014, 32'h0000_0000);

    // div_val=0 with div_en=1 ticks every cycle
    wr(12'h004, 32'h0000_0000);
    wr(12'h008, 32'h0000_0000);
    wr(12'h000, 32'h0000_0003);
    idle(6);
    wr(12'h000, 32'h0000_0000);
    rd("div0_tdr0", 12'h004, 32'd7);

    // reset in the middle of counting
    wr(12'h014, 32'h0000_0001);
    wr(12'h000, 32'h0000_0001);
    idle(5);
    #3;
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_tim_int", {31'd0, tim_int}, 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    idle(2);
    rd("midrst_tdr0",  12'h004, 32'h0000_0000);
    rd("midrst_tcr",   12'h000, 32'h0000_0000);
    rd("midrst_tcmp1", 12'h010, 32'hFFFF_FFFF);
    rd("midrst_tier",  12'h014, 32'h0000_0000);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
